board_move_engine: RTL and testbench

Sequential, parametrised N×N sliding-tile move engine for the 2048 datapath. It sits between the button/direction decoder and the board state register. On a `start` handshake it snapshots the packed board and compacts/merges one line per clock in the requested direction with full 2048 semantics: complete gap removal, at most one merge per tile, and saturation at the maximum tile code. It reports the result board plus move, score and merge statistics.

---
 rtl/board_pkg.sv | 17 +
 rtl/board_move_engine_line_merge.sv | 54 +++++
 rtl/board_move_engine.sv | 148 ++++++++++++++
 tb/tb_board_move_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared definitions for the 2048 move engine: directions, FSM states and the
// cell packing helper ((0,0) lives in the MSBs of the packed board).
package board_pkg;

  localparam logic [1:0] DIR_TO_ROW0 = 2'd0;
  localparam logic [1:0] DIR_TO_ROWN = 2'd1;
  localparam logic [1:0] DIR_TO_COL0 = 2'd2;
  localparam logic [1:0] DIR_TO_COLN = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Cell number within the packed board; multiply by the cell width for the bit offset.
  function automatic int cell_idx(input int n, input int r, input int c);
    return n * n - 1 - (r * n + c);
  endfunction

endpackage

// File: rtl/board_move_engine_line_merge.sv
// Combinational 2048 rule for one line: compact, merge each pair at most once
// (never past the maximum code), zero-pad. Element 0 is the leading edge.
module line_merge #(
  parameter int unsigned N      = 4,
  parameter int unsigned TILE_W = 4,
  parameter int unsigned LS_W   = (1 << TILE_W) + $clog2(N),
  parameter int unsigned LM_W   = $clog2(N / 2 + 1)
) (
  input  logic [N*TILE_W-1:0] line_in,
  output logic [N*TILE_W-1:0] line_out,
  output logic [LM_W-1:0]     merges,
  output logic [LS_W-1:0]     score
);

  localparam logic [TILE_W-1:0] TILE_MAX = '1;

  // One spare slot so the pair compare at the last position reads an empty cell.
  logic [TILE_W-1:0] comp [N+1];
  int unsigned       cnt;
  int unsigned       o;
  logic              skip;

  always_comb begin
    for (int i = 0; i <= N; i++) comp[i] = '0;
    line_out = '0;
    merges   = '0;
    score    = '0;
    cnt      = 0;
    o        = 0;
    skip     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (line_in[i*TILE_W +: TILE_W] != '0) begin
        comp[cnt] = line_in[i*TILE_W +: TILE_W];
        cnt = cnt + 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[i] != '0) begin
        if (comp[i] == comp[i+1] && comp[i] != TILE_MAX) begin
          line_out[o*TILE_W +: TILE_W] = comp[i] + 1'b1;
          merges = merges + 1'b1;
          score  = score + (LS_W'(1) << (comp[i] + 1'b1));
          skip   = 1'b1;
        end else begin
          line_out[o*TILE_W +: TILE_W] = comp[i];
        end
        o = o + 1;
      end
    end
  end

endmodule

// File: rtl/board_move_engine.sv
// Sequential 2048 move engine: snapshots the board on start, merges one line per
// cycle in the requested direction, then presents the result with statistics.
module board_move_engine
  import board_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned TILE_W  = 4,
  parameter int unsigned SCORE_W = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   dir,
  input  logic [N*N*TILE_W-1:0]        board_in,
  output logic                         ready,
  output logic                         done,
  output logic [N*N*TILE_W-1:0]        board_out,
  output logic                         moved,
  output logic [SCORE_W-1:0]           score_delta,
  output logic [$clog2(N*N/2+1)-1:0]   merge_count,
  output logic [TILE_W-1:0]            max_tile
);

  localparam int unsigned BW    = N * N * TILE_W;
  localparam int unsigned KW    = $clog2(N);
  localparam int unsigned MC_W  = $clog2(N * N / 2 + 1);
  localparam int unsigned LM_W  = $clog2(N / 2 + 1);
  localparam int unsigned LS_W  = (1 << TILE_W) + $clog2(N);
  localparam int unsigned SUM_W = ((SCORE_W > LS_W) ? SCORE_W : LS_W) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_e            state_q;
  logic [KW-1:0]     k_q;
  logic [1:0]        dir_q;
  logic [BW-1:0]     work_q;
  logic [BW-1:0]     snap_q;
  logic [SCORE_W-1:0] score_q;
  logic [MC_W-1:0]   merge_q;

  logic [N*TILE_W-1:0] line_in;
  logic [N*TILE_W-1:0] line_out;
  logic [LM_W-1:0]     line_merges;
  logic [LS_W-1:0]     line_score;
  logic [BW-1:0]       work_next;
  logic [SUM_W-1:0]    score_sum;
  logic [SCORE_W-1:0]  score_next;
  logic [MC_W-1:0]     merge_next;
  logic [TILE_W-1:0]   max_next;

  // Cell number of element j (leading edge first) of line k for direction d.
  function automatic int line_cell(input logic [1:0] d, input int k, input int j);
    int idx;
    idx = 0;
    unique case (d)
      DIR_TO_ROW0: idx = cell_idx(N, j, k);
      DIR_TO_ROWN: idx = cell_idx(N, N - 1 - j, k);
      DIR_TO_COL0: idx = cell_idx(N, k, j);
      DIR_TO_COLN: idx = cell_idx(N, k, N - 1 - j);
    endcase
    return idx;
  endfunction

  line_merge #(
    .N      (N),
    .TILE_W (TILE_W),
    .LS_W   (LS_W),
    .LM_W   (LM_W)
  ) u_line_merge (
    .line_in  (line_in),
    .line_out (line_out),
    .merges   (line_merges),
    .score    (line_score)
  );

  always_comb begin
    line_in   = '0;
    work_next = work_q;
    for (int j = 0; j < N; j++) begin
      line_in[j*TILE_W +: TILE_W] = work_q[TILE_W*line_cell(dir_q, int'(k_q), j) +: TILE_W];
    end
    for (int j = 0; j < N; j++) begin
      work_next[TILE_W*line_cell(dir_q, int'(k_q), j) +: TILE_W] = line_out[j*TILE_W +: TILE_W];
    end
    max_next = '0;
    for (int i = 0; i < N * N; i++) begin
      if (work_next[i*TILE_W +: TILE_W] > max_next) max_next = work_next[i*TILE_W +: TILE_W];
    end
    score_sum  = SUM_W'(score_q) + SUM_W'(line_score);
    score_next = (|score_sum[SUM_W-1:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];
    merge_next = merge_q + MC_W'(line_merges);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      dir_q       <= '0;
      work_q      <= '0;
      snap_q      <= '0;
      score_q     <= '0;
      merge_q     <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      board_out   <= '0;
      moved       <= 1'b0;
      score_delta <= '0;
      merge_count <= '0;
      max_tile    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            ready   <= 1'b0;
            work_q  <= board_in;
            snap_q  <= board_in;
            dir_q   <= dir;
            k_q     <= '0;
            score_q <= '0;
            merge_q <= '0;
          end
        end
        RUN: begin
          work_q  <= work_next;
          score_q <= score_next;
          merge_q <= merge_next;
          k_q     <= k_q + 1'b1;
          if (k_q == K_LAST) begin
            state_q     <= DONE;
            done        <= 1'b1;
            board_out   <= work_next;
            moved       <= (work_next != snap_q);
            score_delta <= score_next;
            merge_count <= merge_next;
            max_tile    <= max_next;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
          ready   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_move_engine.sv
// Directed bench for board_move_engine with hand-computed 2048 move results.
module tb_board_move_engine;

  localparam int N  = 4;
  localparam int TW = 4;
  localparam int BW = N * N * TW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    dir = 2'd0;
  logic [BW-1:0] board_in = '0;
  logic          ready;
  logic          done;
  logic [BW-1:0] board_out;
  logic          moved;
  logic [19:0]   score_delta;
  logic [3:0]    merge_count;
  logic [TW-1:0] max_tile;

  int checks = 0;
  int failures = 0;

  board_move_engine #(.N(N), .TILE_W(TW), .SCORE_W(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dir         (dir),
    .board_in    (board_in),
    .ready       (ready),
    .done        (done),
    .board_out   (board_out),
    .moved       (moved),
    .score_delta (score_delta),
    .merge_count (merge_count),
    .max_tile    (max_tile)
  );

  always #5 clk = ~clk;

  // Waits for ready, issues one move, returns cycles from start until done is seen.
  task automatic run_move(input logic [BW-1:0] b, input logic [1:0] d, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    board_in = b;
    dir = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++;
    if (board_out !== '0 || moved !== 1'b0 || score_delta !== '0 || merge_count !== '0 ||
        max_tile !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%b/%0d/%0d/%h want=0", board_out, moved, score_delta,
               merge_count, max_tile);
    end
  endtask

  task automatic test_row_merge();
    int lat;
    run_move(64'h1111_0000_0000_0000, 2'd2, lat);
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL row_latency got=%0d want=5", lat); end
    checks++;
    if (board_out !== 64'h2200_0000_0000_0000) begin
      failures++; $display("FAIL row_board got=%h want=2200000000000000", board_out);
    end
    checks++;
    if (score_delta !== 20'd8) begin failures++; $display("FAIL row_score got=%0d want=8", score_delta); end
    checks++;
    if (merge_count !== 4'd2) begin failures++; $display("FAIL row_merges got=%0d want=2", merge_count); end
    checks++;
    if (moved !== 1'b1) begin failures++; $display("FAIL row_moved got=%b want=1", moved); end
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL row_ready_in_done got=%b want=0", ready); end
  endtask

  task automatic test_col_merge();
    int lat;
    run_move(64'h1000_1000_2000_0000, 2'd0, lat);
    checks++;
    if (board_out !== 64'h2000_2000_0000_0000) begin
      failures++; $display("FAIL col_board got=%h want=2000200000000000", board_out);
    end
    checks++;
    if (score_delta !== 20'd4 || merge_count !== 4'd1) begin
      failures++; $display("FAIL col_stats got=%0d/%0d want=4/1", score_delta, merge_count);
    end
    checks++;
    if (max_tile !== 4'h2) begin failures++; $display("FAIL col_max got=%h want=2", max_tile); end
  endtask

  task automatic test_noop_saturation();
    int lat;
    run_move(64'hFF00_0000_0000_0000, 2'd2, lat);
    checks++;
    if (board_out !== 64'hFF00_0000_0000_0000) begin
      failures++; $display("FAIL sat_board got=%h want=ff00000000000000", board_out);
    end
    checks++;
    if (moved !== 1'b0 || score_delta !== 20'd0 || merge_count !== 4'd0) begin
      failures++; $display("FAIL sat_stats got=%b/%0d/%0d want=0/0/0", moved, score_delta, merge_count);
    end
    checks++;
    if (max_tile !== 4'hF) begin failures++; $display("FAIL sat_max got=%h want=f", max_tile); end
  endtask

  task automatic test_zero_board();
    int lat;
    run_move(64'h0, 2'd1, lat);
    checks++;
    if (moved !== 1'b0 || board_out !== '0 || max_tile !== '0) begin
      failures++; $display("FAIL zero_board got=%b/%h/%h want=0/0/0", moved, board_out, max_tile);
    end
  endtask

  task automatic test_gap_single_merge();
    int lat;
    run_move(64'h2020_1110_0000_0000, 2'd3, lat);
    checks++;
    if (board_out !== 64'h0003_0012_0000_0000) begin
      failures++; $display("FAIL gap_board got=%h want=0003001200000000", board_out);
    end
    checks++;
    if (score_delta !== 20'd12 || merge_count !== 4'd2) begin
      failures++; $display("FAIL gap_stats got=%0d/%0d want=12/2", score_delta, merge_count);
    end
    run_move(64'h2110_0000_0000_0000, 2'd2, lat);
    checks++;
    if (board_out !== 64'h2200_0000_0000_0000 || score_delta !== 20'd4) begin
      failures++; $display("FAIL nomerge_twice got=%h/%0d want=2200000000000000/4", board_out, score_delta);
    end
  endtask

  task automatic test_ignored_start();
    int cnt;
    int extra;
    cnt = 0;
    @(negedge clk);
    while (ready !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    cnt = 0;
    start = 1'b1; board_in = 64'h2110_0000_0000_0000; dir = 2'd2;
    @(negedge clk); cnt++;
    start = 1'b0; board_in = 64'h1111_1111_1111_1111; dir = 2'd3;
    @(negedge clk); cnt++;
    start = 1'b1;
    @(negedge clk); cnt++;
    start = 1'b0;
    while (done !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    checks++;
    if (cnt !== 5) begin failures++; $display("FAIL ign_latency got=%0d want=5", cnt); end
    checks++;
    if (board_out !== 64'h2200_0000_0000_0000 || merge_count !== 4'd1) begin
      failures++; $display("FAIL ign_board got=%h/%0d want=2200000000000000/1", board_out, merge_count);
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL ign_extra_done got=%0d want=0", extra); end
  endtask

  task automatic test_back_to_back();
    int n;
    int ndone;
    int first;
    int second;
    n = 0; ndone = 0; first = 0; second = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    start = 1'b1; board_in = 64'h1111_0000_0000_0000; dir = 2'd2;
    for (int i = 1; i <= 30 && ndone < 2; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          first = i;
          checks++;
          if (board_out !== 64'h2200_0000_0000_0000) begin
            failures++; $display("FAIL b2b_first got=%h want=2200000000000000", board_out);
          end
          board_in = 64'h2200_0000_0000_0000;
        end else begin
          second = i;
          start = 1'b0;
          checks++;
          if (board_out !== 64'h3000_0000_0000_0000 || score_delta !== 20'd8) begin
            failures++; $display("FAIL b2b_second got=%h/%0d want=3000000000000000/8", board_out, score_delta);
          end
        end
      end
    end
    start = 1'b0;
    checks++;
    if (first !== 5 || second - first !== 6) begin
      failures++; $display("FAIL b2b_timing got=%0d/%0d want=5/6", first, second - first);
    end
  endtask

  task automatic test_reset_mid_move();
    int n;
    int seen;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    start = 1'b1; board_in = 64'h1111_0000_0000_0000; dir = 2'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL rstmid_state got=%b/%b want=1/0", ready, done);
    end
    checks++;
    if (board_out !== '0 || score_delta !== '0 || merge_count !== '0 || moved !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs got=%h/%0d/%0d/%b want=0", board_out, score_delta,
                          merge_count, moved);
    end
    seen = 0;
    repeat (8) begin @(negedge clk); if (done === 1'b1) seen++; end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL rstmid_done got=%0d want=0", seen); end
    rst = 1'b1; start = 1'b1; board_in = 64'h1111_0000_0000_0000;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    seen = 0;
    repeat (8) begin @(negedge clk); if (done === 1'b1) seen++; end
    checks++;
    if (seen !== 0 || ready !== 1'b1) begin
      failures++; $display("FAIL rst_start_same got=%0d/%b want=0/1", seen, ready);
    end
  endtask

  initial begin
    test_reset();
    test_row_merge();
    test_col_merge();
    test_noop_saturation();
    test_zero_board();
    test_gap_single_merge();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
